// File: rtl/cv32e40p_pkg.sv
// Shared types and constants for the CV32E40P write-back buffer.
// Holds the FIFO entry layout, the depth ceiling and the push-qualification helper.
package cv32e40p_pkg;

  localparam int WB_BUF_DEPTH_MAX = 8;
  localparam int WB_ADDR_W        = 6;
  localparam int WB_DATA_W        = 32;
  localparam int WB_RPORTS        = 3;

  typedef struct packed {
    logic                 valid;
    logic [WB_ADDR_W-1:0] waddr;
    logic [WB_DATA_W-1:0] wdata;
  } wb_entry_t;

  // x0 is hardwired to zero, so writes to it never occupy an entry.
  function automatic logic wb_write_req(input logic we, input logic [WB_ADDR_W-1:0] waddr);
    return we && (waddr != '0);
  endfunction

endpackage

// File: rtl/cv32e40p_wb_fwd_lookup.sv
// Youngest-match search over the pending write-back entries for one read port.
// entries_i is age ordered: index 0 is the oldest entry, index DEPTH-1 the youngest slot.
module cv32e40p_wb_fwd_lookup
  import cv32e40p_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wb_entry_t [DEPTH-1:0] entries_i,
  input  logic [WB_ADDR_W-1:0]  raddr_i,
  output logic                  hit_o,
  output logic [WB_DATA_W-1:0]  data_o
);

  // Later matches overwrite earlier ones, so the youngest matching entry wins.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    if (raddr_i != '0) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (entries_i[i].valid && (entries_i[i].waddr == raddr_i)) begin
          hit_o  = 1'b1;
          data_o = entries_i[i].wdata;
        end
      end
    end
  end

endmodule

// File: rtl/cv32e40p_wb_buffer.sv
// Write-back buffer between EX and the register file: dual-push FIFO with forwarding lookup.
// Optional feature macro CV32E40P_WB_FWD_EN: forward pending data instead of stalling ID.
module cv32e40p_wb_buffer
  import cv32e40p_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_we_i,
  input  logic [5:0]  alu_waddr_i,
  input  logic [31:0] alu_wdata_i,
  input  logic        lsu_we_i,
  input  logic [5:0]  lsu_waddr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic        wb_ready_o,
  input  logic        rf_ready_i,
  output logic        rf_we_o,
  output logic [5:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  input  logic [17:0] raddr_i,
  output logic [2:0]  fwd_hit_o,
  output logic [95:0] fwd_data_o,
  output logic        raw_stall_o,
  output logic [3:0]  occupancy_o
);

  localparam int         PTR_W     = $clog2(DEPTH);
  localparam logic [3:0] DEPTH_CNT = 4'(DEPTH);

  if ((DEPTH < 2) || (DEPTH > WB_BUF_DEPTH_MAX)) begin : g_bad_depth
    $error("cv32e40p_wb_buffer: DEPTH must be within 2..WB_BUF_DEPTH_MAX");
  end

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  wb_entry_t [DEPTH-1:0] entries_q, entries_d;
  wb_entry_t [DEPTH-1:0] age_view;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      slot1_ptr, age_idx;
  logic [3:0]            count_q, count_d;
  logic [3:0]            free_cnt;
  logic                  lsu_req, alu_req;
  logic                  lsu_push, alu_push, pop;
  wb_entry_t             lsu_entry, alu_entry;

  // Handshake: EX may present writes only while wb_ready_o is high; the
  // register file consumes the head entry on a cycle with rf_we_o & rf_ready_i.
  always_comb begin
    lsu_req   = wb_write_req(lsu_we_i, lsu_waddr_i);
    alu_req   = wb_write_req(alu_we_i, alu_waddr_i);
    free_cnt  = DEPTH_CNT - count_q;
    // Room is judged on registered state; writes beyond the free slots are dropped.
    lsu_push  = lsu_req && (free_cnt != 4'd0);
    alu_push  = alu_req && (free_cnt > (lsu_push ? 4'd1 : 4'd0));
    pop       = (count_q != 4'd0) && rf_ready_i;
    lsu_entry = '{valid: 1'b1, waddr: lsu_waddr_i, wdata: lsu_wdata_i};
    alu_entry = '{valid: 1'b1, waddr: alu_waddr_i, wdata: alu_wdata_i};
    slot1_ptr = ptr_next(wr_ptr_q);

    entries_d = entries_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;

    if (pop) begin
      entries_d[rd_ptr_q].valid = 1'b0;
      rd_ptr_d                  = ptr_next(rd_ptr_q);
    end

    // LSU is the older write, so it takes the first free slot.
    if (lsu_push) begin
      entries_d[wr_ptr_q] = lsu_entry;
      if (alu_push) begin
        entries_d[slot1_ptr] = alu_entry;
        wr_ptr_d             = ptr_next(slot1_ptr);
      end else begin
        wr_ptr_d = slot1_ptr;
      end
    end else if (alu_push) begin
      entries_d[wr_ptr_q] = alu_entry;
      wr_ptr_d            = slot1_ptr;
    end

    count_d = count_q + {3'b000, lsu_push} + {3'b000, alu_push} - {3'b000, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entries_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      entries_q <= entries_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  assign wb_ready_o  = (free_cnt >= 4'd2);
  assign occupancy_o = count_q;
  assign rf_we_o     = (count_q != 4'd0);
  assign rf_waddr_o  = rf_we_o ? entries_q[rd_ptr_q].waddr : '0;
  assign rf_wdata_o  = rf_we_o ? entries_q[rd_ptr_q].wdata : '0;

  // Rotate storage so the lookup sees entries oldest-first starting at the head.
  always_comb begin
    age_idx = rd_ptr_q;
    for (int i = 0; i < DEPTH; i++) begin
      age_view[i] = entries_q[age_idx];
      age_idx     = ptr_next(age_idx);
    end
  end

  logic [2:0]  lookup_hit;
  logic [95:0] lookup_data;

  for (genvar g = 0; g < WB_RPORTS; g++) begin : g_lookup
    cv32e40p_wb_fwd_lookup #(
      .DEPTH (DEPTH)
    ) u_lookup (
      .entries_i (age_view),
      .raddr_i   (raddr_i[g*WB_ADDR_W +: WB_ADDR_W]),
      .hit_o     (lookup_hit[g]),
      .data_o    (lookup_data[g*WB_DATA_W +: WB_DATA_W])
    );
  end

`ifdef CV32E40P_WB_FWD_EN
  assign fwd_hit_o   = lookup_hit;
  assign fwd_data_o  = lookup_data;
  assign raw_stall_o = 1'b0;
`else
  logic unused_lookup_data;
  assign unused_lookup_data = ^lookup_data;
  assign fwd_hit_o   = '0;
  assign fwd_data_o  = '0;
  assign raw_stall_o = |lookup_hit;
`endif

`ifndef SYNTHESIS
  a_no_push_when_not_ready : assert property (
    @(posedge clk) disable iff (!rst_n) (lsu_req || alu_req) |-> wb_ready_o
  );
`endif

endmodule

// File: tb/tb_cv32e40p_wb_buffer.sv
// Self-checking bench for cv32e40p_wb_buffer: scoreboard of expected register-file writes.
// Expectations for forwarding vs. stalling follow CV32E40P_WB_FWD_EN as compiled.
module tb_cv32e40p_wb_buffer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        alu_we_i, lsu_we_i;
  logic [5:0]  alu_waddr_i, lsu_waddr_i;
  logic [31:0] alu_wdata_i, lsu_wdata_i;
  logic        wb_ready_o;
  logic        rf_ready_i;
  logic        rf_we_o;
  logic [5:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic [17:0] raddr_i;
  logic [2:0]  fwd_hit_o;
  logic [95:0] fwd_data_o;
  logic        raw_stall_o;
  logic [3:0]  occupancy_o;

  logic [37:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  cv32e40p_wb_buffer #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alu_we_i    (alu_we_i),
    .alu_waddr_i (alu_waddr_i),
    .alu_wdata_i (alu_wdata_i),
    .lsu_we_i    (lsu_we_i),
    .lsu_waddr_i (lsu_waddr_i),
    .lsu_wdata_i (lsu_wdata_i),
    .wb_ready_o  (wb_ready_o),
    .rf_ready_i  (rf_ready_i),
    .rf_we_o     (rf_we_o),
    .rf_waddr_o  (rf_waddr_o),
    .rf_wdata_o  (rf_wdata_o),
    .raddr_i     (raddr_i),
    .fwd_hit_o   (fwd_hit_o),
    .fwd_data_o  (fwd_data_o),
    .raw_stall_o (raw_stall_o),
    .occupancy_o (occupancy_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 100000");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Driver tasks
  task automatic wb_drive(input logic lwe, input logic [5:0] la, input logic [31:0] ld,
                          input logic awe, input logic [5:0] aa, input logic [31:0] ad);
    lsu_we_i    = lwe;
    lsu_waddr_i = la;
    lsu_wdata_i = ld;
    alu_we_i    = awe;
    alu_waddr_i = aa;
    alu_wdata_i = ad;
    if (lwe && (la != 6'd0)) exp_q.push_back({la, ld});
    if (awe && (aa != 6'd0)) exp_q.push_back({aa, ad});
  endtask

  task automatic wb_next();
    @(posedge clk);
    #1;
    lsu_we_i = 1'b0;
    alu_we_i = 1'b0;
  endtask

  task automatic wb_cycle(input logic lwe, input logic [5:0] la, input logic [31:0] ld,
                          input logic awe, input logic [5:0] aa, input logic [31:0] ad);
    wb_drive(lwe, la, ld, awe, aa, ad);
    wb_next();
  endtask

  task automatic drain(input string tag);
    int n;
    n          = 0;
    rf_ready_i = 1'b1;
    while ((exp_q.size() != 0) && (n < 40)) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_occ"}, 64'(occupancy_o), 64'd0);
  endtask

  // Scoreboard: a write leaves the buffer on every cycle with rf_we_o & rf_ready_i.
  always @(negedge clk) begin
    if (rst_n && rf_we_o && rf_ready_i) begin
      if (exp_q.size() == 0) begin
        check("rf_write_unexpected", 64'(rf_we_o), 64'd0);
      end else begin
        check("rf_write", 64'({rf_waddr_o, rf_wdata_o}), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    rf_ready_i  = 1'b1;
    lsu_we_i    = 1'b0;
    alu_we_i    = 1'b0;
    lsu_waddr_i = '0;
    alu_waddr_i = '0;
    lsu_wdata_i = '0;
    alu_wdata_i = '0;
    raddr_i     = {6'd7, 6'd7, 6'd7};

    // Reset values
    #12;
    check("rst_rf_we", 64'(rf_we_o), 64'd0);
    check("rst_rf_waddr", 64'(rf_waddr_o), 64'd0);
    check("rst_rf_wdata", 64'(rf_wdata_o), 64'd0);
    check("rst_wb_ready", 64'(wb_ready_o), 64'd1);
    check("rst_fwd_hit", 64'(fwd_hit_o), 64'd0);
    check("rst_fwd_data_or", 64'(|fwd_data_o), 64'd0);
    check("rst_raw_stall", 64'(raw_stall_o), 64'd0);
    check("rst_occ", 64'(occupancy_o), 64'd0);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    raddr_i = '0;

    // Dual push, one-cycle latency, LSU before ALU
    wb_cycle(1'b1, 6'd5, 32'hAAAA0000, 1'b1, 6'd6, 32'h00001234);
    check("lat_rf_we", 64'(rf_we_o), 64'd1);
    check("lat_first_addr", 64'(rf_waddr_o), 64'd5);
    check("lat_first_data", 64'(rf_wdata_o), 64'hAAAA0000);
    wb_next();
    check("lat_second_addr", 64'(rf_waddr_o), 64'd6);
    check("lat_second_data", 64'(rf_wdata_o), 64'h1234);
    wb_next();
    check("lat_empty_we", 64'(rf_we_o), 64'd0);

    // Write to x0 is discarded
    wb_cycle(1'b0, 6'd0, 32'd0, 1'b1, 6'd0, 32'h0000FFFF);
    check("x0_occ", 64'(occupancy_o), 64'd0);
    check("x0_rf_we", 64'(rf_we_o), 64'd0);

    // Same-address pair: lookup ignores in-flight pushes, then sees the ALU value
    rf_ready_i = 1'b0;
    raddr_i    = {6'd9, 6'd7, 6'd0};
    wb_drive(1'b1, 6'd7, 32'h11, 1'b1, 6'd7, 32'h22);
    #2;
    check("inflight_hit", 64'(fwd_hit_o), 64'd0);
    check("inflight_stall", 64'(raw_stall_o), 64'd0);
    wb_next();
`ifdef CV32E40P_WB_FWD_EN
    check("fwd_hit", 64'(fwd_hit_o), 64'b010);
    check("fwd_data1", 64'(fwd_data_o[63:32]), 64'h22);
    check("fwd_data0", 64'(fwd_data_o[31:0]), 64'd0);
    check("fwd_data2", 64'(fwd_data_o[95:64]), 64'd0);
    check("fwd_stall", 64'(raw_stall_o), 64'd0);
`else
    check("raw_stall", 64'(raw_stall_o), 64'd1);
    check("raw_fwd_hit", 64'(fwd_hit_o), 64'd0);
    check("raw_fwd_data", 64'(|fwd_data_o), 64'd0);
`endif
    raddr_i = {6'd9, 6'd5, 6'd0};
    #1;
    check("miss_hit", 64'(fwd_hit_o), 64'd0);
    check("miss_stall", 64'(raw_stall_o), 64'd0);
    raddr_i = '0;
    drain("same_addr");

    // Fill to full with the register file stalled, then free one entry
    rf_ready_i = 1'b0;
    wb_cycle(1'b1, 6'd1, 32'hA1, 1'b1, 6'd2, 32'hA2);
    wb_cycle(1'b1, 6'd3, 32'hA3, 1'b1, 6'd4, 32'hA4);
    check("full_occ", 64'(occupancy_o), 64'd4);
    check("full_ready", 64'(wb_ready_o), 64'd0);
    wb_next();
    check("hold_addr", 64'(rf_waddr_o), 64'd1);
    check("hold_data", 64'(rf_wdata_o), 64'hA1);
    rf_ready_i = 1'b1;
    wb_next();
    rf_ready_i = 1'b0;
    check("pop1_occ", 64'(occupancy_o), 64'd3);
    check("pop1_ready", 64'(wb_ready_o), 64'd0);
    check("pop1_head", 64'(rf_waddr_o), 64'd2);
    drain("full");

    // Ten single pushes with continuous pop across the pointer wrap
    rf_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) wb_cycle(1'b1, 6'(8 + i), $urandom, 1'b0, 6'd0, 32'd0);
      else            wb_cycle(1'b0, 6'd0, 32'd0, 1'b1, 6'(8 + i), $urandom);
      check("stream_no_gap", 64'(rf_we_o), 64'd1);
    end
    drain("stream");

    // Random legal traffic with random back-pressure
    for (int i = 0; i < 60; i++) begin
      check("rand_occ", 64'(occupancy_o), 64'(exp_q.size()));
      check("rand_ready", 64'(wb_ready_o), 64'((DEPTH - exp_q.size()) >= 2));
      rf_ready_i = 1'($urandom_range(0, 1));
      if (exp_q.size() <= DEPTH - 2) begin
        wb_cycle(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), $urandom,
                 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), $urandom);
      end else begin
        wb_next();
      end
    end
    drain("random");

    // Reset with three pending entries discards them
    rf_ready_i = 1'b0;
    wb_cycle(1'b1, 6'd20, 32'hB0, 1'b1, 6'd21, 32'hB1);
    wb_cycle(1'b1, 6'd22, 32'hB2, 1'b0, 6'd0, 32'd0);
    check("prerst_occ", 64'(occupancy_o), 64'd3);
    rst_n = 1'b0;
    exp_q.delete();
    #2;
    check("midrst_rf_we", 64'(rf_we_o), 64'd0);
    check("midrst_occ", 64'(occupancy_o), 64'd0);
    wb_next();
    wb_next();
    rst_n      = 1'b1;
    rf_ready_i = 1'b1;
    repeat (5) wb_next();
    check("postrst_rf_we", 64'(rf_we_o), 64'd0);
    check("postrst_occ", 64'(occupancy_o), 64'd0);
    check("postrst_ready", 64'(wb_ready_o), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cv32e40p_wb_buffer.md
CV32E40P_WB_BUFFER -- requirements
Module: cv32e40p_wb_buffer

Interface
REQ-001 Parameter DEPTH, default 4: number of entries in the write-back FIFO; legal range 2..8.
REQ-002 clk  in  1  clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 alu_we_i / alu_waddr_i / alu_wdata_i  in  1/6/32  EX ALU-port write (younger of the two write ports).
REQ-005 lsu_we_i / lsu_waddr_i / lsu_wdata_i  in  1/6/32  EX LSU-port write (older of the two write ports).
REQ-006 wb_ready_o  out  1  buffer can accept two writes this cycle; drives the EX wb_ready input.
REQ-007 rf_ready_i  in  1  register-file write port is free this cycle.
REQ-008 rf_we_o / rf_waddr_o / rf_wdata_o  out  1/6/32  register-file write, taken from the FIFO head.
REQ-009 raddr_i  in  3x6  ID-stage read addresses.
REQ-010 fwd_hit_o  out  3  per-port forwarding hit.
REQ-011 fwd_data_o  out  3x32  per-port forwarded data.
REQ-012 raw_stall_o  out  1  ID must stall on a read-after-write hazard against a pending entry.
REQ-013 occupancy_o  out  4  number of valid entries.

Function
REQ-014 Up to two pushes per cycle; a write is pushed only when its we is 1 and its waddr != 0.
REQ-015 Push order in one cycle: the LSU write is pushed first (older), the ALU write second.
REQ-016 wb_ready_o = (DEPTH - occupancy) >= 2; this is combinational from registered state only.
REQ-017 A push while wb_ready_o is 0 is illegal; an assertion flags it, and the FIFO state does not corrupt (the excess write is dropped).
REQ-018 rf_we_o = FIFO non-empty; rf_waddr_o and rf_wdata_o come from the head entry; pop happens when rf_we_o & rf_ready_i.
REQ-019 Latency is exactly 1 cycle: a write pushed in cycle N appears on rf_we_o in cycle N+1 if the FIFO was empty.
REQ-020 Push and pop occur in the same cycle: occupancy_next = occupancy + pushes - pop; a full FIFO with pop and 0 pushes frees one entry.
REQ-021 Pointers wrap modulo DEPTH; no entry loss at wrap-around.
REQ-022 Two pushes to the same address both enter the FIFO, in order; the register file ends with the ALU value.
REQ-023 Forwarding lookup is combinational: for each port p, fwd_hit_o[p] = 1 when raddr_i[p] != 0 matches any valid entry; fwd_data_o[p] is the data of the youngest matching entry, otherwise 0.
REQ-024 Writes being pushed in the current cycle are not visible to lookup until the next cycle.
REQ-025 rf_ready_i held at 0 holds the head stable (rf_waddr_o and rf_wdata_o unchanged).

Reset
REQ-026 On reset: occupancy 0, pointers 0, and all entry valid bits 0.
REQ-027 Outputs under reset: rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, wb_ready_o=1, fwd_hit_o=0, fwd_data_o=0, raw_stall_o=0, occupancy_o=0.
REQ-028 Reset asserted mid-operation discards all pending entries; none are written afterwards.

Configuration
REQ-029 Macro CV32E40P_WB_FWD_EN, when defined: the REQ-023 forwarding is active and raw_stall_o is tied 0.
REQ-030 Without the macro: fwd_hit_o and fwd_data_o are tied 0, and raw_stall_o = OR over p of (raddr_i[p] != 0 and it matches any valid entry).

Structure
REQ-031 A wb_entry_t typedef (valid, waddr[5:0], wdata[31:0]) and the WB_BUF_DEPTH_MAX=8 constant live in cv32e40p_pkg.
REQ-032 One sub-module, cv32e40p_wb_fwd_lookup, holds the youngest-match priority search and is instantiated 3 times.

Verification
REQ-033 Reset, then LSU write x5=0xAAAA0000 and ALU write x6=0x1234 in the same cycle -> next cycle rf shows x5, and x6 one cycle after, with rf_ready_i=1.
REQ-034 DEPTH=4, rf_ready_i=0, two dual pushes -> occupancy_o=4 and wb_ready_o=0; rf_ready_i=1 for 1 cycle -> occupancy_o=3, wb_ready_o still 0.
REQ-035 ALU write x0=0xFFFF -> occupancy_o stays 0 and rf_we_o stays 0.
REQ-036 With the macro, pending x7=0x11 then x7=0x22, raddr_i[1]=7 -> fwd_hit_o=3'b010 and fwd_data_o[1]=0x22; without the macro -> raw_stall_o=1.
REQ-037 Ten single pushes with continuous pop (wrap-around) -> all ten writes appear in order with no gaps; reset asserted with occupancy 3 -> rf_we_o=0 after reset.
